// File: rtl/game_pkg.sv
// Shared types and default tuning constants for the game controller.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        LOST = 2'd3
    } game_state_t;

    localparam int JUMP_VEL_DEF     = 12;
    localparam int GRAVITY_DEF      = 1;
    localparam int MAX_HEIGHT_DEF   = 100;
    localparam int RESULT_TICKS_DEF = 120;

    localparam int DIST_W = 10;
    localparam int VEL_W  = 8;

endpackage

// File: rtl/game_controller_if.sv
// Game controller signal bundle: upstream buttons/flags in, screen selects and height out.
interface game_controller_if;
    import game_pkg::*;

    logic              game_tick;
    logic              jump_btn;
    logic              start_btn;
    logic              win;
    logic              dead;
    logic [DIST_W-1:0] distance;
    logic              menuScreen;
    logic              playerWon;
    logic              playerLost;

    modport master (
        output game_tick, jump_btn, start_btn, win, dead,
        input  distance, menuScreen, playerWon, playerLost
    );

    modport slave (
        input  game_tick, jump_btn, start_btn, win, dead,
        output distance, menuScreen, playerWon, playerLost
    );

endinterface

// File: rtl/game_controller_btn_edge.sv
// Two-flop synchronizer for a raw button followed by a rising-edge detector.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain plus one history flop for the edge compare
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Pulse is sampled by the consumer on the third edge after the raw rise
    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Game state machine and jump physics feeding the video generator.
module game_controller
    import game_pkg::*;
#(
    parameter int JUMP_VEL     = JUMP_VEL_DEF,
    parameter int GRAVITY      = GRAVITY_DEF,
    parameter int MAX_HEIGHT   = MAX_HEIGHT_DEF,
    parameter int RESULT_TICKS = RESULT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    game_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(RESULT_TICKS + 1);

    game_state_t              state_q, state_d;
    logic [DIST_W-1:0]        dist_q, dist_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic                     pend_q, pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     menu_q, won_q, lost_q;

    logic                     jump_pulse_s;
    logic                     start_pulse_s;
    logic                     grounded_s;
    logic                     consume_s;
    logic signed [11:0]       sum_s;
    logic signed [VEL_W:0]    vdec_s;
    logic signed [VEL_W-1:0]  vdec_sat_s;

    btn_edge u_jump_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.jump_btn),
        .pulse_o (jump_pulse_s)
    );

    btn_edge u_start_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.start_btn),
        .pulse_o (start_pulse_s)
    );

    assign grounded_s = (dist_q == {DIST_W{1'b0}}) && (vel_q == {VEL_W{1'b0}});
    assign sum_s      = $signed({2'b00, dist_q}) + $signed({{(12-VEL_W){vel_q[VEL_W-1]}}, vel_q});
    assign vdec_s     = $signed({vel_q[VEL_W-1], vel_q}) - $signed((VEL_W+1)'(GRAVITY));

    // Velocity decrement saturating at the most negative representable value
    always_comb begin
        vdec_sat_s = vdec_s[VEL_W-1:0];
        if (vdec_s < -$signed((VEL_W+1)'(128))) begin
            vdec_sat_s = {1'b1, {(VEL_W-1){1'b0}}};
        end else begin
            vdec_sat_s = vdec_s[VEL_W-1:0];
        end
    end

    // Next-state, result timer, jump request and physics
    always_comb begin
        state_d   = state_q;
        dist_d    = dist_q;
        vel_d     = vel_q;
        cnt_d     = cnt_q;
        consume_s = 1'b0;

        case (state_q)
            MENU: begin
                if (start_pulse_s) state_d = PLAY;
                else               state_d = MENU;
            end
            PLAY: begin
                if (bus.dead)     state_d = LOST;
                else if (bus.win) state_d = WON;
                else              state_d = PLAY;
            end
            WON, LOST: begin
                if (start_pulse_s) begin
                    state_d = MENU;
                end else if (bus.game_tick && (cnt_q == CNT_W'(RESULT_TICKS - 1))) begin
                    state_d = MENU;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = MENU;
        endcase

        if (((state_q == WON) || (state_q == LOST)) && (state_d == state_q)) begin
            if (bus.game_tick) cnt_d = cnt_q + CNT_W'(1);
            else               cnt_d = cnt_q;
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end

        if ((state_q != PLAY) || (state_d != PLAY)) begin
            dist_d = {DIST_W{1'b0}};
            vel_d  = {VEL_W{1'b0}};
        end else if (bus.game_tick) begin
            if (grounded_s) begin
                if (pend_q) begin
                    dist_d    = DIST_W'(JUMP_VEL);
                    vel_d     = VEL_W'(JUMP_VEL - GRAVITY);
                    consume_s = 1'b1;
                end else begin
                    dist_d = dist_q;
                    vel_d  = vel_q;
                end
            end else if ((sum_s <= 12'sd0) && (vel_q < 0)) begin
                dist_d = {DIST_W{1'b0}};
                vel_d  = {VEL_W{1'b0}};
            end else if ((sum_s >= $signed(12'(MAX_HEIGHT))) && (vel_q > 0)) begin
                // Clamp only while rising so a stalled player at the ceiling starts falling
                dist_d = DIST_W'(MAX_HEIGHT);
                vel_d  = {VEL_W{1'b0}};
            end else begin
                dist_d = sum_s[DIST_W-1:0];
                vel_d  = vdec_sat_s;
            end
        end else begin
            dist_d = dist_q;
            vel_d  = vel_q;
        end

        if ((state_q == PLAY) && (state_d == PLAY)) begin
            pend_d = jump_pulse_s | (pend_q & ~consume_s);
        end else begin
            pend_d = 1'b0;
        end
    end

    // State, physics registers and screen selects decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MENU;
            dist_q  <= {DIST_W{1'b0}};
            vel_q   <= {VEL_W{1'b0}};
            pend_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            menu_q  <= 1'b1;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dist_q  <= dist_d;
            vel_q   <= vel_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            menu_q  <= (state_d == MENU);
            won_q   <= (state_d == WON);
            lost_q  <= (state_d == LOST);
        end
    end

    assign bus.distance   = dist_q;
    assign bus.menuScreen = menu_q;
    assign bus.playerWon  = won_q;
    assign bus.playerLost = lost_q;

endmodule
